vec3_operand_loader: RTL and testbench

- Upstream front-end for the combinational 3D vector ALU (op codes 0 ADD, 1 SUB, 2 CROSS, 3 SCALAR, 4 DOT, 5 COMPARATOR, 6 ORTHOGONAL).
- Deserialises a 7-byte command frame from an 8-bit valid/ready stream into registered operands and drives them onto the ALU.
- Waits a fixed settle time, then captures the ALU results and presents them on a valid/ready result port.
- Single command in flight; there is no overlap between frames.

---
 rtl/vec3_pkg.sv | 31 +++
 rtl/vec3_operand_regs.sv | 39 +++
 rtl/vec3_operand_loader.sv | 195 +++++++++++++++++++
 tb/tb_vec3_operand_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec3_pkg.sv
// Shared definitions for the vec3 operand loader: opcodes, FSM state
// encoding, frame and datapath widths.
package vec3_pkg;

  localparam int FRAME_BEATS = 7;
  localparam int VEC_W       = 8;
  localparam int RES_W       = 16;

  localparam logic [2:0] OP_ADD        = 3'd0;
  localparam logic [2:0] OP_SUB        = 3'd1;
  localparam logic [2:0] OP_CROSS      = 3'd2;
  localparam logic [2:0] OP_SCALAR     = 3'd3;
  localparam logic [2:0] OP_DOT        = 3'd4;
  localparam logic [2:0] OP_COMPARATOR = 3'd5;
  localparam logic [2:0] OP_ORTHOGONAL = 3'd6;
  localparam logic [2:0] OP_RSVD       = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RESULT = 2'd3
  } state_e;

  // An op byte is rejected when its upper bits are non-zero or it names the
  // reserved opcode; the frame is still consumed so framing stays aligned.
  function automatic logic is_bad_op(input logic [VEC_W-1:0] op_byte);
    return (op_byte[7:3] != 5'd0) || (op_byte[2:0] == OP_RSVD);
  endfunction

endpackage

// File: rtl/vec3_operand_regs.sv
// Six 8-bit operand registers (ax, ay, az, bx, by, bz) written by beat index
// 1..6 of a command frame, with a synchronous clear.
module vec3_operand_regs
  import vec3_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [2:0]       beat_i,
  input  logic [VEC_W-1:0] wdata_i,
  output logic [VEC_W-1:0] ax_o,
  output logic [VEC_W-1:0] ay_o,
  output logic [VEC_W-1:0] az_o,
  output logic [VEC_W-1:0] bx_o,
  output logic [VEC_W-1:0] by_o,
  output logic [VEC_W-1:0] bz_o
);

  logic [VEC_W-1:0] ops_q [6];

  // Beat n (1..6) lands in operand slot n-1; beat 0 is the op byte and writes nothing here.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < 6; i++) ops_q[i] <= '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < 6; i++) begin
        if (beat_i == 3'(i + 1)) ops_q[i] <= wdata_i;
      end
    end
  end

  assign ax_o = ops_q[0];
  assign ay_o = ops_q[1];
  assign az_o = ops_q[2];
  assign bx_o = ops_q[3];
  assign by_o = ops_q[4];
  assign bz_o = ops_q[5];

endmodule

// File: rtl/vec3_operand_loader.sv
// Front-end for the 3D vector ALU: deserialises a 7-byte command frame,
// drives registered operands to the ALU, waits SETTLE_CYCLES edges, then
// captures and presents the ALU result on a valid/ready port.
// Optional: define VEC3_LOADER_CMD_COUNT_EN to add a 16-bit cmd_count output
// counting result handshakes.
//
// state  | meaning
// IDLE   | waiting for the op byte of a new frame
// LOAD   | accepting operand beats 1..6
// SETTLE | operands stable, counting down ALU settle time
// RESULT | captured result offered, waiting for res_ready
module vec3_operand_loader
  import vec3_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_data,
  output logic [2:0]       alu_op,
  output logic [VEC_W-1:0] alu_ax,
  output logic [VEC_W-1:0] alu_ay,
  output logic [VEC_W-1:0] alu_az,
  output logic [VEC_W-1:0] alu_bx,
  output logic [VEC_W-1:0] alu_by,
  output logic [VEC_W-1:0] alu_bz,
  input  logic [RES_W-1:0] alu_rx,
  input  logic [RES_W-1:0] alu_ry,
  input  logic [RES_W-1:0] alu_rz,
  input  logic [RES_W-1:0] alu_ans,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_op,
  output logic [RES_W-1:0] res_x,
  output logic [RES_W-1:0] res_y,
  output logic [RES_W-1:0] res_z,
  output logic [RES_W-1:0] res_ans,
  output logic             res_err,
  output logic             busy
`ifdef VEC3_LOADER_CMD_COUNT_EN
  ,
  output logic [15:0]      cmd_count
`endif
);

  state_e           state_q, state_d;
  logic [2:0]       beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             err_q, err_d;
  logic             load_en, capture, res_hs, accept;

  logic [2:0]       res_op_q;
  logic [RES_W-1:0] res_x_q, res_y_q, res_z_q, res_ans_q;
  logic             res_err_q;

  // FSM state plus frame bookkeeping (beat index, settle count, op, error flag).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign accept = in_valid & in_ready;

  // Next-state and frame sequencing.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    err_d   = err_q;
    load_en = 1'b0;
    capture = 1'b0;
    res_hs  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = in_data[2:0];
          err_d   = is_bad_op(in_data);
          beat_d  = 3'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          load_en = 1'b1;
          if (beat_q == 3'(FRAME_BEATS - 1)) begin
            beat_d  = '0;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = SETTLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state only.
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
      LOAD:    in_ready  = 1'b1;
      RESULT:  res_valid = 1'b1;
      default: ;
    endcase
  end

  vec3_operand_regs u_regs (
    .clk_i   (clk),
    .clr_i   (rst),
    .wr_en_i (load_en),
    .beat_i  (beat_q),
    .wdata_i (in_data),
    .ax_o    (alu_ax),
    .ay_o    (alu_ay),
    .az_o    (alu_az),
    .bx_o    (alu_bx),
    .by_o    (alu_by),
    .bz_o    (alu_bz)
  );

  assign alu_op = op_q;

  // Result capture at the end of settle; a rejected command reports zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_op_q  <= '0;
      res_err_q <= 1'b0;
      res_x_q   <= '0;
      res_y_q   <= '0;
      res_z_q   <= '0;
      res_ans_q <= '0;
    end else if (capture) begin
      res_op_q  <= op_q;
      res_err_q <= err_q;
      res_x_q   <= err_q ? '0 : alu_rx;
      res_y_q   <= err_q ? '0 : alu_ry;
      res_z_q   <= err_q ? '0 : alu_rz;
      res_ans_q <= err_q ? '0 : alu_ans;
    end
  end

  assign res_op  = res_op_q;
  assign res_err = res_err_q;
  assign res_x   = res_x_q;
  assign res_y   = res_y_q;
  assign res_z   = res_z_q;
  assign res_ans = res_ans_q;

`ifdef VEC3_LOADER_CMD_COUNT_EN
  logic [15:0] cmd_cnt_q;

  // Counts every result handshake, error results included; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)         cmd_cnt_q <= '0;
    else if (res_hs) cmd_cnt_q <= cmd_cnt_q + 16'd1;
  end

  assign cmd_count = cmd_cnt_q;
`endif

endmodule

// File: tb/tb_vec3_operand_loader.sv
// Bench for vec3_operand_loader: a stand-in vector ALU, a frame-level model
// of the loader, a per-cycle compare process and directed/random frames.
module tb_vec3_operand_loader;

  localparam int S = 2;

  typedef struct packed {
    logic [15:0] x, y, z, ans;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic [2:0]  alu_op;
  logic [7:0]  alu_ax, alu_ay, alu_az, alu_bx, alu_by, alu_bz;
  logic [15:0] alu_rx, alu_ry, alu_rz, alu_ans;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [2:0]  res_op;
  logic [15:0] res_x, res_y, res_z, res_ans;
  logic        res_err;
  logic        busy;
`ifdef VEC3_LOADER_CMD_COUNT_EN
  logic [15:0] cmd_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  vec3_operand_loader #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .alu_op    (alu_op),
    .alu_ax    (alu_ax),
    .alu_ay    (alu_ay),
    .alu_az    (alu_az),
    .alu_bx    (alu_bx),
    .alu_by    (alu_by),
    .alu_bz    (alu_bz),
    .alu_rx    (alu_rx),
    .alu_ry    (alu_ry),
    .alu_rz    (alu_rz),
    .alu_ans   (alu_ans),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_op    (res_op),
    .res_x     (res_x),
    .res_y     (res_y),
    .res_z     (res_z),
    .res_ans   (res_ans),
    .res_err   (res_err),
    .busy      (busy)
`ifdef VEC3_LOADER_CMD_COUNT_EN
    ,
    .cmd_count (cmd_count)
`endif
  );

  // Reference vector ALU: unsigned operands, 16-bit wrapping results.
  function automatic res_t alu_f(input logic [2:0] op,
                                 input logic [7:0] ax, input logic [7:0] ay, input logic [7:0] az,
                                 input logic [7:0] bx, input logic [7:0] by, input logic [7:0] bz);
    res_t r;
    logic [15:0] a0, a1, a2, b0, b1, b2, d;
    r  = '0;
    a0 = 16'(ax); a1 = 16'(ay); a2 = 16'(az);
    b0 = 16'(bx); b1 = 16'(by); b2 = 16'(bz);
    d  = a0 * b0 + a1 * b1 + a2 * b2;
    case (op)
      3'd0: begin r.x = a0 + b0; r.y = a1 + b1; r.z = a2 + b2; end
      3'd1: begin r.x = a0 - b0; r.y = a1 - b1; r.z = a2 - b2; end
      3'd2: begin r.x = a1 * b2 - a2 * b1; r.y = a2 * b0 - a0 * b2; r.z = a0 * b1 - a1 * b0; end
      3'd3: begin r.x = a0 * b0; r.y = a1 * b0; r.z = a2 * b0; end
      3'd4: r.ans = d;
      3'd5: r.ans = ((a0 == b0) && (a1 == b1) && (a2 == b2)) ? 16'd1 : 16'd0;
      3'd6: r.ans = (d == 16'd0) ? 16'd1 : 16'd0;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {alu_rx, alu_ry, alu_rz, alu_ans} = alu_f(alu_op, alu_ax, alu_ay, alu_az, alu_bx, alu_by, alu_bz);

  // Frame-level model: counts accepted bytes, waits S edges after the last
  // one, then holds the expected result until it is taken.
  int          m_beats = 0;
  int          m_rem   = 0;
  bit          m_have  = 1'b0;
  logic [7:0]  m_frame [7];
  logic [2:0]  m_alu_op = '0;
  logic [7:0]  m_ops [6];
  res_t        m_res = '0;
  logic [2:0]  m_res_op = '0;
  bit          m_res_err = 1'b0;
  logic [15:0] m_count = '0;

  initial begin
    for (int i = 0; i < 6; i++) m_ops[i] = '0;
    for (int i = 0; i < 7; i++) m_frame[i] = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_beats = 0; m_rem = 0; m_have = 1'b0; m_alu_op = '0;
        for (int i = 0; i < 6; i++) m_ops[i] = '0;
        m_res = '0; m_res_op = '0; m_res_err = 1'b0; m_count = '0;
      end else if (m_have) begin
        if (res_ready) begin
          m_have  = 1'b0;
          m_count = m_count + 16'd1;
        end
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_have    = 1'b1;
          m_res_op  = m_frame[0][2:0];
          m_res_err = (m_frame[0][7:3] != 5'd0) || (m_frame[0][2:0] == 3'd7);
          m_res     = m_res_err ? '0 : alu_f(m_frame[0][2:0], m_frame[1], m_frame[2], m_frame[3],
                                             m_frame[4], m_frame[5], m_frame[6]);
        end
      end else if (in_valid) begin
        m_frame[m_beats] = in_data;
        if (m_beats == 0) m_alu_op = in_data[2:0];
        else              m_ops[m_beats-1] = in_data;
        m_beats = m_beats + 1;
        if (m_beats == 7) begin
          m_beats = 0;
          m_rem   = S;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready",  32'(in_ready),  32'(!(m_rem > 0 || m_have)));
        chk("busy",      32'(busy),      32'(m_beats > 0 || m_rem > 0 || m_have));
        chk("res_valid", 32'(res_valid), 32'(m_have));
        chk("alu_op",    32'(alu_op),    32'(m_alu_op));
        chk("alu_ax",    32'(alu_ax),    32'(m_ops[0]));
        chk("alu_ay",    32'(alu_ay),    32'(m_ops[1]));
        chk("alu_az",    32'(alu_az),    32'(m_ops[2]));
        chk("alu_bx",    32'(alu_bx),    32'(m_ops[3]));
        chk("alu_by",    32'(alu_by),    32'(m_ops[4]));
        chk("alu_bz",    32'(alu_bz),    32'(m_ops[5]));
        chk("res_op",    32'(res_op),    32'(m_res_op));
        chk("res_err",   32'(res_err),   32'(m_res_err));
        chk("res_x",     32'(res_x),     32'(m_res.x));
        chk("res_y",     32'(res_y),     32'(m_res.y));
        chk("res_z",     32'(res_z),     32'(m_res.z));
        chk("res_ans",   32'(res_ans),   32'(m_res.ans));
`ifdef VEC3_LOADER_CMD_COUNT_EN
        chk("cmd_count", 32'(cmd_count), 32'(m_count));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (!in_ready) chk("accept_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send7(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                       input logic [7:0] b6, input int maxgap);
    logic [7:0] f [7];
    f = '{b0, b1, b2, b3, b4, b5, b6};
    for (int i = 0; i < 7; i++) send_byte(f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_result();
    int t;
    t = 0;
    while (!res_valid && t < 60) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      tick();
      t++;
    end
    in_valid = 1'b0;
    chk("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic consume(input int delay);
    repeat (delay) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    logic [4:0] hi;

    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset in_ready",  32'(in_ready),  32'd1);
    chk("reset busy",      32'(busy),      32'd0);
    chk("reset res_valid", 32'(res_valid), 32'd0);

    // ADD with exact latency: low one edge after bz, high two edges after.
    send7(8'h00, 8'h03, 8'h04, 8'h05, 8'h01, 8'h02, 8'h03, 0);
    chk("add lat E0", 32'(res_valid), 32'd0);
    tick();
    chk("add lat E0+1", 32'(res_valid), 32'd0);
    tick();
    chk("add lat E0+2", 32'(res_valid), 32'd1);
    chk("add res_x",   32'(res_x),   32'h0004);
    chk("add res_y",   32'(res_y),   32'h0006);
    chk("add res_z",   32'(res_z),   32'h0008);
    chk("add res_err", 32'(res_err), 32'd0);
    consume(0);

    // DOT.
    send7(8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 0);
    wait_result();
    chk("dot res_ans", 32'(res_ans), 32'h0020);
    chk("dot res_op",  32'(res_op),  32'd4);
    consume(0);

    // CROSS (1,0,0)x(0,1,0) held under backpressure for 10 cycles.
    send7(8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 0);
    wait_result();
    repeat (10) tick();
    chk("bp res_valid", 32'(res_valid), 32'd1);
    chk("bp in_ready",  32'(in_ready),  32'd0);
    chk("bp res_z",     32'(res_z),     32'h0001);
    consume(0);
    chk("post hs in_ready",  32'(in_ready),  32'd1);
    chk("post hs res_valid", 32'(res_valid), 32'd0);

    // Reserved opcode, then malformed op byte, then a good SCALAR frame.
    send7(8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 0);
    wait_result();
    chk("rsvd res_err", 32'(res_err), 32'd1);
    chk("rsvd res_x",   32'(res_x),   32'd0);
    chk("rsvd res_ans", 32'(res_ans), 32'd0);
    consume(1);
    send7(8'h0A, 8'h05, 8'h06, 8'h07, 8'h01, 8'h01, 8'h01, 0);
    wait_result();
    chk("malformed res_err", 32'(res_err), 32'd1);
    chk("malformed res_y",   32'(res_y),   32'd0);
    consume(0);
    send7(8'h03, 8'h01, 8'h02, 8'h03, 8'h05, 8'hAA, 8'hBB, 0);
    wait_result();
    chk("scalar res_err", 32'(res_err), 32'd0);
    chk("scalar res_x",   32'(res_x),   32'h0005);
    chk("scalar res_z",   32'(res_z),   32'h000F);
    consume(0);

    // Reset after three accepted beats discards the partial frame.
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    pulse_reset();
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst alu_ax",   32'(alu_ax),   32'd0);
    chk("midrst res_z",    32'(res_z),    32'd0);
    send7(8'h01, 8'h09, 8'h08, 8'h07, 8'h01, 8'h02, 8'h03, 0);
    wait_result();
    chk("sub res_x", 32'(res_x), 32'h0008);
    chk("sub res_y", 32'(res_y), 32'h0006);
    chk("sub res_z", 32'(res_z), 32'h0004);
    consume(0);

    // 50 random frames with input gaps and random result backpressure.
    pulse_reset();
    for (int n = 0; n < 50; n++) begin
      op = 3'($urandom);
      hi = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'd0;
      send7({hi, op}, 8'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 3);
      wait_result();
      consume(int'($urandom_range(0, 4)));
    end
`ifdef VEC3_LOADER_CMD_COUNT_EN
    chk("cmd_count after 50", 32'(cmd_count), 32'd50);
`endif
    chk("final busy", 32'(busy), 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
